fib_seq_engine: RTL and testbench

Self-sequencing Fibonacci term generator. It replaces the externally driven opcode/register-address datapath with an internal FSM, a parametrised data width and a streaming valid/ready output. On `start` it emits terms F(0)..F(N-1), one per handshake, and reports wrap-around (overflow) and zero terms. It sits between the top-level control and the display/consumer logic.

---
 rtl/fib_pkg.sv | 23 ++
 rtl/fib_regfile.sv | 47 ++++
 rtl/fib_seq_engine.sv | 138 +++++++++++++
 tb/tb_fib_seq_engine.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequence engine:
// FSM state encoding, reset values and the two seed terms.
package fib_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EMIT  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } fib_state_t;

    localparam int FIB_F0 = 0;
    localparam int FIB_F1 = 1;

    localparam fib_state_t RST_STATE = S_IDLE;

    // Register-file slots that hold a, b and tmp right after reset or start
    localparam logic [1:0] RST_A_PTR = 2'd0;
    localparam logic [1:0] RST_B_PTR = 2'd1;
    localparam logic [1:0] RST_T_PTR = 2'd2;

endpackage

// File: rtl/fib_regfile.sv
// 4-entry term storage with a wrap bit per entry: two async read ports,
// one synchronous write port and an init strobe that seeds F(0)/F(1).
module fib_regfile
    import fib_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wwrap,
    input  logic [1:0]        raddr0,
    input  logic [1:0]        raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic              rwrap0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rwrap1
);

    logic [3:0][DATA_W-1:0] mem;
    logic [3:0]             wrap;

    // init always seeds the reset slots, matching the pointer reset in the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            mem  <= '0;
            wrap <= '0;
        end else if (init) begin
            mem[RST_A_PTR]  <= DATA_W'(FIB_F0);
            mem[RST_B_PTR]  <= DATA_W'(FIB_F1);
            wrap[RST_A_PTR] <= 1'b0;
            wrap[RST_B_PTR] <= 1'b0;
        end else if (we) begin
            mem[waddr]  <= wdata;
            wrap[waddr] <= wwrap;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rwrap0 = wrap[raddr0];
    assign rdata1 = mem[raddr1];
    assign rwrap1 = wrap[raddr1];

endmodule

// File: rtl/fib_seq_engine.sv
// Self-sequencing Fibonacci term generator with a valid/ready output stream.
// Define FIB_STOP_ON_OVF_EN to end the sequence instead of emitting a wrapped term.
module fib_seq_engine
    import fib_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic [DATA_W-1:0] term_data,
    output logic              term_valid,
    input  logic              term_ready,
    output logic [CNT_W-1:0]  term_idx,
    output logic              zero_flag,
    output logic              ovf,
    output logic              done
);

`ifdef FIB_STOP_ON_OVF_EN
    localparam bit STOP_ON_OVF = 1'b1;
`else
    localparam bit STOP_ON_OVF = 1'b0;
`endif

    fib_state_t        state, nxt;
    logic [1:0]        a_ptr, b_ptr, t_ptr;
    logic [CNT_W-1:0]  n, idx;
    logic              vld, ovf_q;
    logic [DATA_W-1:0] a_val, b_val;
    logic              wa, wb;
    logic [DATA_W:0]   sum;
    logic              init, we, nxt_wa;

    assign sum = {1'b0, a_val} + {1'b0, b_val};

    // a/b/tmp live in the regfile; SHIFT rotates pointers instead of moving data
    fib_regfile #(.DATA_W(DATA_W)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .we     (we),
        .waddr  (t_ptr),
        .wdata  (sum[DATA_W-1:0]),
        .wwrap  (sum[DATA_W] | wa | wb),
        .raddr0 (a_ptr),
        .raddr1 (b_ptr),
        .rdata0 (a_val),
        .rwrap0 (wa),
        .rdata1 (b_val),
        .rwrap1 (wb)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RST_STATE;
        else     state <= nxt;
    end

    always_comb begin
        nxt    = state;
        init   = 1'b0;
        we     = 1'b0;
        nxt_wa = wa;
        case (state)
            S_IDLE: begin
                if (start) begin
                    init   = 1'b1;
                    nxt_wa = 1'b0;
                    nxt    = (count == '0) ? S_DONE : S_EMIT;
                end
            end
            S_EMIT: begin
                if (STOP_ON_OVF && wa)
                    nxt = S_DONE;
                else if (term_ready)
                    nxt = (idx == n - CNT_W'(1)) ? S_DONE : S_ADD;
            end
            S_ADD: begin
                we  = 1'b1;
                nxt = S_SHIFT;
            end
            S_SHIFT: begin
                nxt_wa = wb;
                nxt    = S_EMIT;
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // valid and ovf are computed for the state being entered so both are
    // visible in the same cycle the term is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            n     <= '0;
            idx   <= '0;
            a_ptr <= RST_A_PTR;
            b_ptr <= RST_B_PTR;
            t_ptr <= RST_T_PTR;
            vld   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            vld <= (nxt == S_EMIT) && !(STOP_ON_OVF && nxt_wa);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n     <= count;
                        idx   <= '0;
                        a_ptr <= RST_A_PTR;
                        b_ptr <= RST_B_PTR;
                        t_ptr <= RST_T_PTR;
                        ovf_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    a_ptr <= b_ptr;
                    b_ptr <= t_ptr;
                    t_ptr <= a_ptr;
                    idx   <= idx + CNT_W'(1);
                end
                default: ;
            endcase
            if (nxt == S_EMIT && nxt_wa) ovf_q <= 1'b1;
        end
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign term_valid = vld;
    assign term_data  = vld ? a_val : '0;
    assign term_idx   = vld ? idx : '0;
    assign zero_flag  = vld && (a_val == '0);
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Directed-vector bench for fib_seq_engine (DATA_W=8, CNT_W=4).
module tb_fib_seq_engine;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, start, term_ready;
    logic [CNT_W-1:0]  count;
    logic              busy, term_valid, zero_flag, ovf, done;
    logic [DATA_W-1:0] term_data;
    logic [CNT_W-1:0]  term_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int s_cyc = 0;

    int hs_data[$], hs_idx[$], hs_zero[$], hs_ovf[$], hs_cyc[$];
    int done_q[$], done_ovf[$], done_busy[$];

    // hand-computed F(0)..F(14), F(14)=377 wraps to 121 in 8 bits
    int FIB[15] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};

    always #5 clk = ~clk;

    fib_seq_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .count      (count),
        .busy       (busy),
        .term_data  (term_data),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term_idx   (term_idx),
        .zero_flag  (zero_flag),
        .ovf        (ovf),
        .done       (done)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (term_valid && term_ready) begin
            hs_data.push_back(int'(term_data));
            hs_idx.push_back(int'(term_idx));
            hs_zero.push_back(int'(zero_flag));
            hs_ovf.push_back(int'(ovf));
            hs_cyc.push_back(cyc);
        end
        if (done) begin
            done_q.push_back(cyc);
            done_ovf.push_back(int'(ovf));
            done_busy.push_back(int'(busy));
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".busy"},  int'(busy), 0);
        chk({tag, ".valid"}, int'(term_valid), 0);
        chk({tag, ".done"},  int'(done), 0);
        chk({tag, ".ovf"},   int'(ovf), 0);
        chk({tag, ".zero"},  int'(zero_flag), 0);
        chk({tag, ".data"},  int'(term_data), 0);
        chk({tag, ".idx"},   int'(term_idx), 0);
    endtask

    task automatic run_seq(input int cnt, input int stall_idx, input int stall_len,
                           input int poke_idx, input int poke_cnt, input int rst_idx);
        int  stall;
        int  budget;
        bit  poked;
        hs_data.delete(); hs_idx.delete(); hs_zero.delete(); hs_ovf.delete(); hs_cyc.delete();
        done_q.delete(); done_ovf.delete(); done_busy.delete();
        stall  = stall_len;
        poked  = 1'b0;
        budget = 0;
        term_ready = 1'b1;
        start = 1'b1;
        count = CNT_W'(cnt);
        tick();
        start = 1'b0;
        s_cyc = cyc;
        while (done_q.size() == 0 && budget < 300) begin
            if (rst_idx >= 0 && term_valid && int'(term_idx) == rst_idx) begin
                term_ready = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                term_ready = 1'b1;
                return;
            end
            if (stall > 0 && term_valid && int'(term_idx) == stall_idx) begin
                term_ready = 1'b0;
                chk($sformatf("stall%0d.data", stall), int'(term_data), FIB[stall_idx]);
                chk($sformatf("stall%0d.idx", stall), int'(term_idx), stall_idx);
                stall--;
            end else begin
                term_ready = 1'b1;
            end
            if (!poked && poke_idx >= 0 && term_valid && int'(term_idx) == poke_idx) begin
                start = 1'b1;
                count = CNT_W'(poke_cnt);
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            budget++;
        end
        start = 1'b0;
        term_ready = 1'b1;
        if (done_q.size() == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic check_seq(input string tag, input int n_exp, input int done_gap,
                             input int exp_done_ovf);
        int last;
        chk({tag, ".nterms"}, hs_data.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < hs_data.size()) begin
                chk($sformatf("%s.data[%0d]", tag, i), hs_data[i], FIB[i]);
                chk($sformatf("%s.idx[%0d]", tag, i),  hs_idx[i], i);
                chk($sformatf("%s.zero[%0d]", tag, i), hs_zero[i], (i == 0) ? 1 : 0);
                chk($sformatf("%s.ovf[%0d]", tag, i),  hs_ovf[i], (i >= 14) ? 1 : 0);
            end
        end
        if (hs_cyc.size() > 0)
            chk({tag, ".first_lat"}, hs_cyc[0] - s_cyc, 1);
        if (hs_cyc.size() > 1)
            chk({tag, ".spacing"}, hs_cyc[1] - hs_cyc[0], 3);
        chk({tag, ".ndone"}, done_q.size(), 1);
        if (done_q.size() > 0) begin
            last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size() - 1] : s_cyc;
            chk({tag, ".done_lat"}, done_q[0] - last, done_gap);
            chk({tag, ".done_ovf"}, done_ovf[0], exp_done_ovf);
            chk({tag, ".done_busy"}, done_busy[0], 1);
        end
        chk({tag, ".busy_after"}, int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        count = '0;
        term_ready = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        run_seq(7, -1, 0, -1, 0, -1);
        check_seq("c7", 7, 1, 0);
        tick();

        run_seq(0, -1, 0, -1, 0, -1);
        check_seq("c0", 0, 1, 0);
        tick();

        run_seq(4, 2, 5, -1, 0, -1);
        check_seq("stall", 4, 1, 0);
        tick();

        run_seq(15, -1, 0, -1, 0, -1);
`ifdef FIB_STOP_ON_OVF_EN
        check_seq("c15", 14, 4, 1);
`else
        check_seq("c15", 15, 1, 1);
`endif
        tick();

        run_seq(7, -1, 0, -1, 0, 3);
        chk_idle_outputs("midrst");
        chk("midrst.nterms", hs_data.size(), 3);
        repeat (3) tick();
        chk("midrst.nodone", done_q.size(), 0);
        run_seq(3, -1, 0, -1, 0, -1);
        check_seq("after_rst", 3, 1, 0);
        tick();

        run_seq(5, -1, 0, 2, 9, -1);
        check_seq("restart", 5, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
